// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller for the 0x8000_xxxx region: UART bridge plus cycle and
// retired-instruction counters, with registered read data aligned to dmem latency.
module mmio_io_ctrl #(
    parameter logic [31:0] IO_BASE  = 32'h8000_0000,
    parameter logic [7:0]  CTRL_OFF = 8'h00,
    parameter logic [7:0]  RX_OFF   = 8'h04,
    parameter logic [7:0]  TX_OFF   = 8'h08,
    parameter logic [7:0]  CYC_OFF  = 8'h10,
    parameter logic [7:0]  INST_OFF = 8'h14,
    parameter logic [7:0]  CRST_OFF = 8'h18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        io_hit,
    output logic [31:0] rdata
);

    logic        w_hit;
    logic [7:0]  w_off;
    logic        w_rd;
    logic        w_wr;
    logic        w_tx_st;
    logic        w_tx_done;
    logic        w_crst;
    logic [31:0] w_rd_mux;

    logic [31:0] r_rdata;
    logic        r_io_hit;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_inst_cnt;

    assign w_hit     = (addr[31:28] == IO_BASE[31:28]);
    assign w_off     = addr[7:0];
    assign w_rd      = re && w_hit;
    assign w_wr      = we && w_hit;
    assign w_tx_st   = w_wr && (w_off == TX_OFF);
    assign w_tx_done = r_tx_valid && tx_ready;
    assign w_crst    = w_wr && (w_off == CRST_OFF);

    // Byte is only consumed when rx_valid is also high; the receiver owns that qualification.
    assign rx_ready  = w_rd && (w_off == RX_OFF) && !rst;

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_off)
            CTRL_OFF: w_rd_mux = {30'b0, rx_valid, !r_tx_valid};
            RX_OFF:   w_rd_mux = {24'b0, rx_data};
            CYC_OFF:  w_rd_mux = r_cyc_cnt;
            INST_OFF: w_rd_mux = r_inst_cnt;
            default:  w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= 32'h0;
            r_io_hit   <= 1'b0;
            r_tx_data  <= 8'h0;
            r_tx_valid <= 1'b0;
            r_cyc_cnt  <= 32'h0;
            r_inst_cnt <= 32'h0;
        end else begin
            r_io_hit <= w_rd;
            if (w_rd)
                r_rdata <= w_rd_mux;

            // A store landing on the handshake edge refills the single-entry buffer.
            if (w_tx_st && (!r_tx_valid || w_tx_done)) begin
                r_tx_data  <= wdata[7:0];
                r_tx_valid <= 1'b1;
            end else if (w_tx_done) begin
                r_tx_valid <= 1'b0;
            end

            if (w_crst) begin
                r_cyc_cnt  <= 32'h0;
                r_inst_cnt <= 32'h0;
            end else begin
                r_cyc_cnt  <= r_cyc_cnt + 32'd1;
                r_inst_cnt <= r_inst_cnt + {31'b0, inst_valid};
            end
        end
    end

    assign rdata    = r_rdata;
    assign io_hit   = r_io_hit;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: hand-computed expectations for decode, UART bridge and counters.
module tb_mmio_io_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_valid;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        io_hit;
    logic [31:0] rdata;

    int n_chk = 0;
    int n_err = 0;

    mmio_io_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .re         (re),
        .inst_valid (inst_valid),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .io_hit     (io_hit),
        .rdata      (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re = 1'b0;
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0;
        inst_valid = 1'b0; rx_data = 8'h0; rx_valid = 1'b0; tx_ready = 1'b0;
        tick();
        tick();
        re = 1'b1; addr = 32'h8000_0004; rx_valid = 1'b1;
        #1;
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_io_hit", {31'b0, io_hit}, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        idle(); rx_valid = 1'b0;
        rst = 1'b0;

        // Ten counted edges, then read the cycle counter.
        repeat (10) tick();
        re = 1'b1; addr = 32'h8000_0010;
        tick();
        chk("cyc_10", rdata, 32'd10);
        chk("cyc_hit", {31'b0, io_hit}, 32'h1);
        idle();
        tick();
        chk("idle_hit", {31'b0, io_hit}, 32'h0);
        chk("idle_hold", rdata, 32'd10);

        // UART receive path.
        rx_valid = 1'b1; rx_data = 8'h5A;
        re = 1'b1; addr = 32'h8000_0000;
        tick();
        chk("ctrl_rx_tx", rdata, 32'h3);
        addr = 32'h8000_0004;
        #1;
        chk("rx_ready_on", {31'b0, rx_ready}, 32'h1);
        tick();
        chk("rx_data", rdata, 32'h5A);
        idle(); rx_valid = 1'b0;

        // TX buffer: fill, drop while full, drain.
        tx_ready = 1'b0;
        we = 1'b1; addr = 32'h8000_0008; wdata = 32'h141;
        tick();
        chk("tx_fill_v", {31'b0, tx_valid}, 32'h1);
        chk("tx_fill_d", {24'b0, tx_data}, 32'h41);
        wdata = 32'h42;
        tick();
        chk("tx_drop_d", {24'b0, tx_data}, 32'h41);
        chk("tx_drop_v", {31'b0, tx_valid}, 32'h1);
        we = 1'b0; re = 1'b1; addr = 32'h8000_0000;
        tick();
        chk("ctrl_full", rdata, 32'h0);
        idle(); tx_ready = 1'b1;
        tick();
        chk("tx_drain", {31'b0, tx_valid}, 32'h0);

        // Handshake and new store in the same cycle.
        tx_ready = 1'b0; we = 1'b1; addr = 32'h8000_0008; wdata = 32'h44;
        tick();
        chk("tx_refill_d", {24'b0, tx_data}, 32'h44);
        tx_ready = 1'b1; wdata = 32'h43;
        tick();
        chk("tx_same_v", {31'b0, tx_valid}, 32'h1);
        chk("tx_same_d", {24'b0, tx_data}, 32'h43);
        idle(); tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        // Counters: clear, count 7 instructions, then clear against a same-cycle increment.
        we = 1'b1; addr = 32'h8000_0018; wdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; inst_valid = 1'b1;
        repeat (7) tick();
        inst_valid = 1'b0; re = 1'b1; addr = 32'h8000_0014;
        tick();
        chk("inst_7", rdata, 32'd7);
        re = 1'b0; inst_valid = 1'b1; we = 1'b1; addr = 32'h8000_0018;
        tick();
        we = 1'b0; inst_valid = 1'b0; re = 1'b1; addr = 32'h8000_0014;
        tick();
        chk("inst_clr", rdata, 32'd0);
        addr = 32'h8000_0010;
        tick();
        chk("cyc_clr", rdata, 32'd1);

        // Unmapped offset, then out-of-region load holds rdata.
        addr = 32'h8000_0020;
        tick();
        chk("unmapped", rdata, 32'h0);
        chk("unmapped_hit", {31'b0, io_hit}, 32'h1);
        rx_valid = 1'b1; rx_data = 8'hA5; addr = 32'h8000_0000;
        tick();
        chk("ctrl_again", rdata, 32'h3);
        addr = 32'h1000_0004;
        #1;
        chk("miss_rx_ready", {31'b0, rx_ready}, 32'h0);
        tick();
        chk("miss_hit", {31'b0, io_hit}, 32'h0);
        chk("miss_hold", rdata, 32'h3);
        idle(); rx_valid = 1'b0;

        // Reset with a pending TX byte.
        we = 1'b1; addr = 32'h8000_0008; wdata = 32'h55;
        tick();
        chk("tx_pend", {31'b0, tx_valid}, 32'h1);
        we = 1'b0; rst = 1'b1;
        tick();
        chk("rst_tx_drop", {31'b0, tx_valid}, 32'h0);
        chk("rst_rdata2", rdata, 32'h0);
        rst = 1'b0; re = 1'b1; addr = 32'h8000_0010;
        tick();
        chk("rst_cyc", rdata, 32'h0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
